divider_arbiter: RTL and testbench

Shares one `serial_divider` datapath between `NREQ` requesters and sequences each divide job. It does round-robin arbitration, latches operands, pulses `div_start_o`, waits for `div_fini_i` with a timeout, and returns the quotient with a per-requester done pulse. Divisors below 2 never raise `div_fini_i`, so the block resolves them locally without touching the datapath. It sits between the user-project glue (Wishbone CSR front-ends, LA probes) and the divider.

---
 rtl/divider_pkg.sv | 17 +
 rtl/rr_picker.sv | 28 ++
 rtl/divider_arbiter.sv | 132 +++++++++++++
 tb/tb_divider_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared states and constants for the serial-divider arbiter.
package divider_pkg;

  localparam int unsigned DefaultXlen = 32;

  // Divide-by-zero result, sliced to XLEN by users (XLEN <= 64).
  localparam logic [63:0] DivZeroQuot = '1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLaunch = 3'd1,
    StArm    = 3'd2,
    StWait   = 3'd3,
    StDone   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            any_o
);

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] p, input int unsigned off);
    int unsigned s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return IdxW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    grant_idx_o = ptr_i;
    any_o       = |req_i;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[wrap_idx(ptr_i, unsigned'(i))]) grant_idx_o = wrap_idx(ptr_i, unsigned'(i));
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin sequencer sharing one serial divider between NREQ requesters,
// with local resolution of divisors 0/1 and a WAIT timeout.
module divider_arbiter
  import divider_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned XLEN    = DefaultXlen,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*XLEN-1:0] dividend_i,
  input  logic [NREQ*XLEN-1:0] divisor_i,
  output logic [NREQ-1:0]      done_o,
  output logic [XLEN-1:0]      quotient_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic [IdxW-1:0]      owner_o,
  output logic                 div_start_o,
  output logic [XLEN-1:0]      div_dividend_o,
  output logic [XLEN-1:0]      div_divisor_o,
  input  logic                 div_fini_i,
  input  logic [XLEN-1:0]      div_quotient_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  arb_state_e      r_state;
  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] r_owner;
  logic [NREQ-1:0] r_done;
  logic [XLEN-1:0] r_quot;
  logic            r_err;
  logic            r_busy;
  logic            r_start;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [CntW-1:0] r_cnt;

  logic [IdxW-1:0] w_grant;
  logic            w_any;
  logic [XLEN-1:0] w_dvd;
  logic [XLEN-1:0] w_dvs;

  rr_picker #(
    .N    (NREQ),
    .IdxW (IdxW)
  ) u_rr_picker (
    .req_i       (req_i),
    .ptr_i       (r_ptr),
    .grant_idx_o (w_grant),
    .any_o       (w_any)
  );

  assign w_dvd = dividend_i[w_grant*XLEN +: XLEN];
  assign w_dvs = divisor_i[w_grant*XLEN +: XLEN];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_owner <= '0;
      r_done  <= '0;
      r_quot  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_owner <= w_grant;
            r_dvd   <= w_dvd;
            r_dvs   <= w_dvs;
            r_busy  <= 1'b1;
            // The divider never finishes for divisors 0/1, so answer locally.
            if (w_dvs < XLEN'(2)) begin
              r_quot  <= (w_dvs == '0) ? DivZeroQuot[XLEN-1:0] : w_dvd;
              r_err   <= (w_dvs == '0);
              r_state <= StDone;
            end else begin
              r_start <= 1'b1;
              r_state <= StLaunch;
            end
          end
        end
        StLaunch: r_state <= StArm;
        StArm: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (div_fini_i) begin
            r_quot  <= div_quotient_i;
            r_err   <= 1'b0;
            r_state <= StDone;
          end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
            r_quot  <= '0;
            r_err   <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_done[r_owner] <= 1'b1;
          r_ptr   <= (r_owner == IdxW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign done_o         = r_done;
  assign quotient_o     = r_quot;
  assign err_o          = r_err;
  assign busy_o         = r_busy;
  assign owner_o        = r_owner;
  assign div_start_o    = r_start;
  assign div_dividend_o = r_dvd;
  assign div_divisor_o  = r_dvs;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: edge-timeline model plus literal pins, with a behavioural divider.
module tb_divider_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [XLEN-1:0] QStale  = 32'hDEAD_BEEF;
  localparam logic [XLEN-1:0] QSecond = 32'h0BAD_F00D;

  logic                 clk_i;
  logic                 reset_i;
  logic [NREQ-1:0]      req_i;
  logic [NREQ*XLEN-1:0] dividend_i;
  logic [NREQ*XLEN-1:0] divisor_i;
  logic [NREQ-1:0]      done_o;
  logic [XLEN-1:0]      quotient_o;
  logic                 err_o;
  logic                 busy_o;
  logic [0:0]           owner_o;
  logic                 div_start_o;
  logic [XLEN-1:0]      div_dividend_o;
  logic [XLEN-1:0]      div_divisor_o;
  logic                 div_fini_i;
  logic [XLEN-1:0]      div_quotient_i;

  divider_arbiter #(
    .NREQ    (NREQ),
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_i          (req_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .done_o         (done_o),
    .quotient_o     (quotient_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .owner_o        (owner_o),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_fini_i     (div_fini_i),
    .div_quotient_i (div_quotient_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;
  int tmo_req = 0;
  int tmo_seen = 0;
  int div_mode = 0;  // 0 normal, 1 never finishes, 2 stale fini then late second result
  int left [NREQ];

  function automatic int unsigned flog2(input logic [XLEN-1:0] v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < int'(XLEN); i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] op_dvd(input int k);
    return dividend_i[k*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] op_dvs(input int k);
    return divisor_i[k*XLEN +: XLEN];
  endfunction

  // ---------------- behavioural divider ----------------
  int f_cnt;
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      f_cnt          <= 0;
      div_fini_i     <= 1'b0;
      div_quotient_i <= '0;
    end else if (div_start_o) begin
      if (div_mode == 2) f_cnt <= 4;
      else begin
        f_cnt      <= (div_mode == 1) ? 0 : int'(flog2({div_divisor_o[XLEN-1:1], 1'b0}));
        div_fini_i <= 1'b0;
      end
    end else if (f_cnt != 0) begin
      f_cnt <= f_cnt - 1;
      if (f_cnt == 1) begin
        div_fini_i     <= 1'b1;
        div_quotient_i <= (div_mode == 2) ? QSecond
                        : div_dividend_o >> flog2({div_divisor_o[XLEN-1:1], 1'b0});
      end else begin
        div_fini_i <= 1'b0;
      end
    end else if (div_mode == 2) begin
      div_fini_i     <= 1'b1;
      div_quotient_i <= QStale;
    end
  end

  // ---------------- expected-behaviour model ----------------
  // Edges are counted from reset release; a job granted at edge e finishes with done_o after D.
  int              ecnt;
  logic            m_active;
  int              m_ptr, m_owner, m_e, m_D;
  logic            m_byp, m_err;
  logic [XLEN-1:0] m_quot, m_dvd, m_dvs;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int g;
    bit found;
    g = 0;
    found = 0;
    for (int off = 0; off < int'(NREQ); off++) begin
      if (!found && r[(p + off) % NREQ]) begin
        g = (p + off) % NREQ;
        found = 1;
      end
    end
    return g;
  endfunction

  function automatic int job_lat(input int k);
    if (op_dvs(k) < 2) return 1;
    if (div_mode == 1) return 3 + TIMEOUT;
    if (div_mode == 2) return 7;
    return 3 + int'(flog2({op_dvs(k)[XLEN-1:1], 1'b0}));
  endfunction

  function automatic logic [XLEN-1:0] job_quot(input int k);
    if (op_dvs(k) == 0) return '1;
    if (op_dvs(k) == 1) return op_dvd(k);
    if (div_mode == 1) return '0;
    if (div_mode == 2) return QSecond;
    return op_dvd(k) >> flog2({op_dvs(k)[XLEN-1:1], 1'b0});
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ecnt <= 0; m_active <= 1'b0; m_ptr <= 0; m_owner <= 0; m_e <= 0; m_D <= 0;
      m_byp <= 1'b0; m_err <= 1'b0; m_quot <= '0; m_dvd <= '0; m_dvs <= '0;
    end else begin
      ecnt <= ecnt + 1;
      if (m_active && ecnt + 1 == m_D) m_ptr <= (m_owner + 1) % NREQ;
      if ((!m_active || ecnt + 1 > m_D) && (|req_i)) begin
        m_active <= 1'b1;
        m_owner  <= pick(req_i, m_ptr);
        m_e      <= ecnt + 1;
        m_D      <= ecnt + 1 + job_lat(pick(req_i, m_ptr));
        m_quot   <= job_quot(pick(req_i, m_ptr));
        m_err    <= (op_dvs(pick(req_i, m_ptr)) == 0) ||
                    (op_dvs(pick(req_i, m_ptr)) >= 2 && div_mode == 1);
        m_byp    <= op_dvs(pick(req_i, m_ptr)) < 2;
        m_dvd    <= op_dvd(pick(req_i, m_ptr));
        m_dvs    <= op_dvs(pick(req_i, m_ptr));
      end
    end
  end

  // ---------------- compare process ----------------
  logic            pin_armed;
  int              pin_edge, pin_owner;
  logic [XLEN-1:0] pin_quot;
  logic            pin_err;
  logic [NREQ-1:0] exp_done;
  logic [NREQ-1:0] one_hot;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t edge=%0d: got %0h, expected %0h", name, $time, ecnt, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (tmo_req != tmo_seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_bound at t=%0t: job did not complete within its cycle budget", $time);
      tmo_seen = tmo_req;
    end
    if (reset_i) begin
      chk("rst_done", done_o, 0);
      chk("rst_quot", quotient_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_owner", owner_o, 0);
      chk("rst_start", div_start_o, 0);
      chk("rst_dvd", div_dividend_o, 0);
      chk("rst_dvs", div_divisor_o, 0);
    end else begin
      one_hot  = 1;
      exp_done = (m_active && ecnt == m_D) ? one_hot << m_owner : '0;
      chk("done", done_o, exp_done);
      chk("busy", busy_o, m_active && ecnt >= m_e && ecnt < m_D);
      chk("start", div_start_o, m_active && !m_byp && ecnt == m_e);
      chk("owner", owner_o, m_owner);
      if (exp_done != 0) begin
        chk("quot", quotient_o, m_quot);
        chk("err", err_o, m_err);
      end
      if (m_active && !m_byp && ecnt >= m_e) begin
        chk("op_dvd", div_dividend_o, m_dvd);
        chk("op_dvs", div_divisor_o, m_dvs);
      end
      if (pin_armed && ecnt == pin_edge) begin
        one_hot = 1;
        chk("pin_done", done_o, one_hot << pin_owner);
        chk("pin_quot", quotient_o, pin_quot);
        chk("pin_err", err_o, pin_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (done_o[k] && left[k] > 0) left[k] = left[k] - 1;
      req_i[k] = (left[k] > 0);
    end
  endtask

  task automatic job(input int k, input logic [XLEN-1:0] dvd, input logic [XLEN-1:0] dvs);
    dividend_i[k*XLEN +: XLEN] = dvd;
    divisor_i[k*XLEN +: XLEN]  = dvs;
    left[k]  = left[k] + 1;
    req_i[k] = 1'b1;
  endtask

  // Literal expectation: done_o for requester `owner` right after edge `rel`, counting the
  // edge that samples the request as edge 1.
  task automatic pin(input int rel, input int owner, input logic [XLEN-1:0] q, input logic e);
    pin_edge  = ecnt + rel;
    pin_owner = owner;
    pin_quot  = q;
    pin_err   = e;
    pin_armed = 1'b1;
  endtask

  task automatic wait_jobs(input int bound);
    int n;
    n = 0;
    while ((left[0] != 0 || left[1] != 0) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) tmo_req++;
    tick();
    pin_armed = 1'b0;
  endtask

  initial begin
    reset_i    = 1'b0;
    req_i      = '0;
    dividend_i = '0;
    divisor_i  = '0;
    pin_armed  = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) left[k] = 0;
    #1 reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // 0x100 / 8 through the divider
    job(0, 32'h0000_0100, 32'd8);
    pin(7, 0, 32'h20, 1'b0);
    wait_jobs(100);

    // Local divide-by-zero and divide-by-one
    job(0, 32'h1234, 32'd0);
    pin(2, 0, 32'hFFFF_FFFF, 1'b1);
    wait_jobs(20);
    job(1, 32'h1234, 32'd1);
    pin(2, 1, 32'h1234, 1'b0);
    wait_jobs(20);

    // Both requesters held high for two jobs each: grants alternate 0,1,0,1
    job(0, 32'h40, 32'd2);
    job(1, 32'h80, 32'd2);
    job(0, 32'h40, 32'd2);
    job(1, 32'h80, 32'd2);
    pin(5, 0, 32'h20, 1'b0);
    wait_jobs(100);

    // Divider never finishes, then a normal job and an odd divisor
    div_mode = 1;
    job(0, 32'h55, 32'd4);
    pin(TIMEOUT + 4, 0, 32'h0, 1'b1);
    wait_jobs(200);
    div_mode = 0;
    job(1, 32'h1000, 32'd16);
    pin(8, 1, 32'h100, 1'b0);
    wait_jobs(100);
    job(0, 32'h300, 32'd5);
    pin(6, 0, 32'hC0, 1'b0);
    wait_jobs(100);

    // Stale fini across LAUNCH/ARM, low for three WAIT cycles, then the real result
    div_mode = 2;
    tick();
    tick();
    job(1, 32'h77, 32'd2);
    pin(8, 1, QSecond, 1'b0);
    wait_jobs(100);
    div_mode = 0;
    tick();

    // Reset during WAIT: job 0 is dropped, pending req1 runs after release
    job(0, 32'hFFFF, 32'h8000_0000);
    job(1, 32'h10, 32'd4);
    repeat (6) tick();
    reset_i  = 1'b1;
    left[0]  = 0;
    req_i[0] = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
    pin(6, 1, 32'h4, 1'b0);
    wait_jobs(100);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
